// File: rtl/spi_mem_cmd_ctrl.sv
// spi_mem_cmd_ctrl: turns framed SPI byte streams (opcode, address, data) into
// req/ack memory transactions, supplies the MISO byte and keeps sticky error bits.
// Optional feature: define SPI_CMD_TIMEOUT_EN to abort requests that are not
// acknowledged within TIMEOUT cycles.
module spi_mem_cmd_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] OpWrite  = 8'h02;
  localparam logic [7:0] OpRead   = 8'h03;
  localparam logic [7:0] OpStatus = 8'h05;
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StOpcode,
    StAddr,
    StWrData,
    StWrWait,
    StRdWait,
    StRdStream,
    StStatus,
    StDiscard
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              op_wr_q, op_wr_d;
  logic              unknown_op_q, unknown_op_d;
  logic              overrun_q, overrun_d;
  // Frame boundaries seen while a request was in flight; honoured once it ends
  logic              pend_end_q, pend_end_d;
  logic              pend_start_q, pend_start_d;
  logic              req_done;
  logic              timeout_err;
  logic [ADDR_W-1:0] addr_from_byte;
  logic [7:0]        status_vec;

  // Start address: zero-extend for wide memories, truncate for narrow ones
  if (ADDR_W > 8) begin : g_addr_wide
    assign addr_from_byte = {{(ADDR_W - 8){1'b0}}, rx_byte};
  end else begin : g_addr_narrow
    assign addr_from_byte = rx_byte[ADDR_W-1:0];
  end

`ifdef SPI_CMD_TIMEOUT_EN
  logic       timeout_err_q, timeout_err_d;
  logic [7:0] tmo_cnt_q;

  // Count cycles of the current request; restart whenever no request is held
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst || !mem_req_q || !mem_req_d) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TmoLast;
  assign timeout_err    = 1'b0;
`endif

  // Busy bit in the status byte reflects a memory transaction in flight
  assign status_vec = {4'b0000, timeout_err, overrun_q, unknown_op_q, mem_req_q};

  // Next-state, transaction and status logic
  always_comb begin
    state_d      = state_q;
    tx_byte_d    = tx_byte_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    op_wr_d      = op_wr_q;
    unknown_op_d = unknown_op_q;
    overrun_d    = overrun_q;
    pend_end_d   = pend_end_q;
    pend_start_d = pend_start_q;
    req_done     = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif

    if (mem_req_q) begin
      // Only WR_WAIT/RD_WAIT hold a request; the handshake always finishes first
      if (frame_end) begin
        pend_end_d   = 1'b1;
        pend_start_d = 1'b0;
      end else if (frame_start) begin
        pend_start_d = 1'b1;
        pend_end_d   = 1'b0;
      end
      if (rx_valid) begin
        overrun_d = 1'b1;
      end
      if (mem_ack) begin
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        req_done   = 1'b1;
        if (mem_we_q) begin
          state_d = StWrData;
        end else begin
          tx_byte_d = mem_rdata;
          state_d   = StRdStream;
        end
      end
`ifdef SPI_CMD_TIMEOUT_EN
      else if (tmo_cnt_q == TmoLast) begin
        mem_req_d     = 1'b0;
        timeout_err_d = 1'b1;
        req_done      = 1'b1;
        state_d       = StDiscard;
      end
`endif
      if (req_done) begin
        if (pend_end_d) begin
          state_d = StIdle;
        end else if (pend_start_d) begin
          state_d = StOpcode;
        end
        pend_end_d   = 1'b0;
        pend_start_d = 1'b0;
      end
    end else if (frame_end) begin
      // Reading status consumes it: sticky bits clear as the STATUS frame closes
      if (state_q == StStatus) begin
        unknown_op_d = 1'b0;
        overrun_d    = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
      end
      state_d = StIdle;
    end else if (frame_start) begin
      state_d = StOpcode;
    end else if (rx_valid) begin
      case (state_q)
        StOpcode: begin
          case (rx_byte)
            OpWrite: begin
              op_wr_d = 1'b1;
              state_d = StAddr;
            end
            OpRead: begin
              op_wr_d = 1'b0;
              state_d = StAddr;
            end
            OpStatus: begin
              tx_byte_d = status_vec;
              state_d   = StStatus;
            end
            default: begin
              unknown_op_d = 1'b1;
              state_d      = StDiscard;
            end
          endcase
        end
        StAddr: begin
          mem_addr_d = addr_from_byte;
          if (op_wr_q) begin
            state_d = StWrData;
          end else begin
            mem_we_d  = 1'b0;
            mem_req_d = 1'b1;
            state_d   = StRdWait;
          end
        end
        StWrData: begin
          mem_wdata_d = rx_byte;
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = StWrWait;
        end
        StRdStream: begin
          // Dummy byte: prefetch the next location for the following slot
          mem_we_d  = 1'b0;
          mem_req_d = 1'b1;
          state_d   = StRdWait;
        end
        default: ;
      endcase
    end

    if (state_d == StIdle || state_d == StOpcode) begin
      tx_byte_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state_q      <= StIdle;
      tx_byte_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      op_wr_q      <= 1'b0;
      unknown_op_q <= 1'b0;
      overrun_q    <= 1'b0;
      pend_end_q   <= 1'b0;
      pend_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_byte_q    <= tx_byte_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      op_wr_q      <= op_wr_d;
      unknown_op_q <= unknown_op_d;
      overrun_q    <= overrun_d;
      pend_end_q   <= pend_end_d;
      pend_start_q <= pend_start_d;
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  // Sticky timeout flag
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  assign tx_byte   = tx_byte_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);
  assign err       = unknown_op_q | overrun_q | timeout_err;

endmodule

// File: tb/tb_spi_mem_cmd_ctrl.sv
// Directed bench for spi_mem_cmd_ctrl: expected memory requests go into a
// scoreboard queue as bytes are sent; a memory responder pops and compares them.
module tb_spi_mem_cmd_ctrl;

  logic       FPGA_clk = 1'b0;
  logic       FPGA_rst;
  logic       frame_start, frame_end, rx_valid;
  logic [7:0] rx_byte, tx_byte, mem_wdata, mem_rdata, mem_addr;
  logic       mem_req, mem_we, mem_ack, busy, err;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] rd_q[$];
  int         ack_delay = 0;  // negative: never acknowledge
  int         n_checks  = 0;
  int         n_fail    = 0;

  always #5 FPGA_clk = ~FPGA_clk;

  spi_mem_cmd_ctrl #(
    .ADDR_W (8),
    .TIMEOUT(8)
  ) dut (
    .FPGA_clk   (FPGA_clk),
    .FPGA_rst   (FPGA_rst),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .tx_byte    (tx_byte),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge FPGA_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge FPGA_clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge FPGA_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge FPGA_clk); #1;
    frame_start = 1'b1;
    @(posedge FPGA_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic end_frame();
    @(posedge FPGA_clk); #1;
    frame_end = 1'b1;
    @(posedge FPGA_clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge FPGA_clk);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'h00);
    check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h00);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h00);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // Memory model: compares each new request against the scoreboard, then acks
  initial begin
    req_t exp;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge FPGA_clk);
      if (mem_req === 1'b1) begin
        check("req_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("req_we", 32'(mem_we), 32'(exp.we));
          check("req_addr", 32'(mem_addr), 32'(exp.addr));
          if (exp.we) check("req_wdata", 32'(mem_wdata), 32'(exp.wdata));
        end
        if (ack_delay >= 0) begin
          repeat (ack_delay) @(negedge FPGA_clk);
          mem_ack   = 1'b1;
          mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
          @(negedge FPGA_clk);
          mem_ack = 1'b0;
          check("req_drop_after_ack", 32'(mem_req), 32'h0);
        end else begin
          for (int i = 0; i < 400 && mem_req === 1'b1; i++) @(negedge FPGA_clk);
          check("req_released", 32'(mem_req), 32'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    FPGA_rst    = 1'b1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
    rx_byte     = 8'h00;
    idle(3);
    FPGA_rst = 1'b0;
    check_reset_values("reset");

    // Write stream with zero-wait ack
    ack_delay = 0;
    start_frame();
    send_byte(8'h02);
    send_byte(8'h10);
    exp_q.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'hAA});
    send_byte(8'hAA);
    idle(2);
    exp_q.push_back('{we: 1'b1, addr: 8'h11, wdata: 8'hBB});
    send_byte(8'hBB);
    idle(3);
    @(negedge FPGA_clk);
    check("wr_addr_after", 32'(mem_addr), 32'h12);
    check("wr_err", 32'(err), 32'h0);
    end_frame();
    idle(1);
    @(negedge FPGA_clk);
    check("wr_busy_after_end", 32'(busy), 32'h0);
    check("wr_scoreboard_empty", 32'(exp_q.size()), 32'h0);

    // Read stream with address wrap
    start_frame();
    send_byte(8'h03);
    exp_q.push_back('{we: 1'b0, addr: 8'hFF, wdata: 8'h00});
    rd_q.push_back(8'h5A);
    send_byte(8'hFF);
    idle(4);
    @(negedge FPGA_clk);
    check("rd_tx_first", 32'(tx_byte), 32'h5A);
    check("rd_addr_wrap", 32'(mem_addr), 32'h00);
    exp_q.push_back('{we: 1'b0, addr: 8'h00, wdata: 8'h00});
    rd_q.push_back(8'hC3);
    send_byte(8'h00);
    idle(4);
    @(negedge FPGA_clk);
    check("rd_tx_second", 32'(tx_byte), 32'hC3);
    exp_q.push_back('{we: 1'b0, addr: 8'h01, wdata: 8'h00});
    rd_q.push_back(8'h11);
    send_byte(8'h00);
    idle(4);
    @(negedge FPGA_clk);
    check("rd_tx_third", 32'(tx_byte), 32'h11);
    end_frame();
    idle(1);
    @(negedge FPGA_clk);
    check("rd_busy_after_end", 32'(busy), 32'h0);
    check("rd_tx_idle", 32'(tx_byte), 32'h00);

    // Unknown opcode, then status read and clear
    start_frame();
    send_byte(8'h7E);
    @(negedge FPGA_clk);
    check("unk_err", 32'(err), 32'h1);
    check("unk_busy_discard", 32'(busy), 32'h1);
    end_frame();
    start_frame();
    send_byte(8'h05);
    @(negedge FPGA_clk);
    check("status_unknown", 32'(tx_byte), 32'h02);
    end_frame();
    idle(1);
    @(negedge FPGA_clk);
    check("status_cleared_err", 32'(err), 32'h0);
    start_frame();
    send_byte(8'h05);
    @(negedge FPGA_clk);
    check("status_clean", 32'(tx_byte), 32'h00);
    end_frame();

    // Overrun: second byte arrives while the first write waits for ack
    ack_delay = 20;
    start_frame();
    send_byte(8'h02);
    send_byte(8'h20);
    exp_q.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'h55});
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge FPGA_clk);
    check("ovr_err", 32'(err), 32'h1);
    check("ovr_req_held", 32'(mem_req), 32'h1);
    idle(30);
    @(negedge FPGA_clk);
    check("ovr_addr_after", 32'(mem_addr), 32'h21);
    check("ovr_scoreboard_empty", 32'(exp_q.size()), 32'h0);
    end_frame();
    ack_delay = 0;
    start_frame();
    send_byte(8'h05);
    @(negedge FPGA_clk);
    check("status_overrun", 32'(tx_byte), 32'h04);
    end_frame();

    // frame_end while a write is outstanding
    ack_delay = 10;
    start_frame();
    send_byte(8'h02);
    send_byte(8'h30);
    exp_q.push_back('{we: 1'b1, addr: 8'h30, wdata: 8'h77});
    send_byte(8'h77);
    idle(2);
    end_frame();
    @(negedge FPGA_clk);
    check("fe_busy_held", 32'(busy), 32'h1);
    check("fe_req_held", 32'(mem_req), 32'h1);
    idle(20);
    @(negedge FPGA_clk);
    check("fe_busy_after", 32'(busy), 32'h0);
    check("fe_req_after", 32'(mem_req), 32'h0);
    check("fe_addr_after", 32'(mem_addr), 32'h31);

    // Reset pulse while a read is outstanding
    ack_delay = -1;
    start_frame();
    send_byte(8'h03);
    exp_q.push_back('{we: 1'b0, addr: 8'h40, wdata: 8'h00});
    send_byte(8'h40);
    idle(2);
    @(negedge FPGA_clk);
    check("rst_req_before", 32'(mem_req), 32'h1);
    @(posedge FPGA_clk); #1;
    FPGA_rst = 1'b1;
    idle(2);
    FPGA_rst = 1'b0;
    check_reset_values("midrst");
    ack_delay = 0;

`ifdef SPI_CMD_TIMEOUT_EN
    begin
      int hi_cycles;
      ack_delay = -1;
      start_frame();
      send_byte(8'h02);
      send_byte(8'h50);
      exp_q.push_back('{we: 1'b1, addr: 8'h50, wdata: 8'h99});
      send_byte(8'h99);
      hi_cycles = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge FPGA_clk);
        if (mem_req !== 1'b1) break;
        hi_cycles++;
      end
      check("tmo_req_cycles", 32'(hi_cycles), 32'd8);
      check("tmo_err", 32'(err), 32'h1);
      check("tmo_busy_discard", 32'(busy), 32'h1);
      end_frame();
      ack_delay = 0;
      start_frame();
      send_byte(8'h05);
      @(negedge FPGA_clk);
      check("status_timeout", 32'(tx_byte), 32'h08);
      end_frame();
    end
`endif

    idle(3);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
